// File: rtl/hs32_mem_arb.sv
// Memory bus arbiter for hs32: the fetch and execute units share one memory bus.
// Each request is registered and only one transaction runs at a time. Execute has
// priority, but fetch is guaranteed a grant after a bounded run of exec grants.
module hs32_mem_arb #(
    parameter int unsigned STARVE  = 4,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_rdy,
    output logic [31:0] f_dtr,
    input  logic        x_req,
    input  logic [31:0] x_addr,
    input  logic        x_rw,
    input  logic [31:0] x_dtw,
    output logic        x_rdy,
    output logic [31:0] x_dtr,
    output logic        m_stb,
    output logic [31:0] m_addr,
    output logic        m_rw,
    output logic [31:0] m_dtw,
    input  logic        m_ack,
    input  logic [31:0] m_dtr,
    output logic        own,
    output logic        bus_err,
    output logic [1:0]  fsm_state,
    output logic [3:0]  starve_cnt
);

    // Handshake: a requester raises req with its address/data stable and keeps it
    // up until it sees its one-cycle rdy pulse. It drops req on the edge that
    // samples rdy. A req still high in the following IDLE cycle is a new request.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE);
    localparam bit         TMO_EN     = (TIMEOUT != 0);
    localparam logic [7:0] TMO_LAST   = TMO_EN ? 8'(TIMEOUT - 1) : 8'd0;

    state_t      state;
    state_t      state_nx;
    logic [7:0]  tmo_cnt;
    logic [7:0]  tmo_nx;
    logic [3:0]  starve_q;
    logic [3:0]  starve_nx;

    logic        any_req;
    logic        grant_x;
    logic        ack_hit;
    logic        tmo_hit;
    logic [31:0] rd_data;

    logic        stb_nx;
    logic [31:0] addr_nx;
    logic        rw_nx;
    logic [31:0] dtw_nx;
    logic        own_nx;
    logic        f_rdy_nx;
    logic        x_rdy_nx;
    logic        err_nx;
    logic [31:0] f_dtr_nx;
    logic [31:0] x_dtr_nx;

    assign any_req = f_req | x_req;
    // Exec wins a tie unless fetch has already waited out STARVE exec grants.
    assign grant_x = x_req & ~(f_req & (starve_q == STARVE_LIM));
    assign ack_hit = (state == ST_BUSY) & m_ack;
    // An ack in the last allowed cycle takes precedence over the timeout.
    assign tmo_hit = TMO_EN & (state == ST_BUSY) & ~m_ack & (tmo_cnt == TMO_LAST);
    assign rd_data = ack_hit ? m_dtr : 32'h0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (any_req) state_nx = ST_BUSY;
            ST_BUSY: if (ack_hit || tmo_hit) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        stb_nx    = m_stb;
        addr_nx   = m_addr;
        rw_nx     = m_rw;
        dtw_nx    = m_dtw;
        own_nx    = own;
        f_rdy_nx  = 1'b0;
        x_rdy_nx  = 1'b0;
        err_nx    = 1'b0;
        f_dtr_nx  = f_dtr;
        x_dtr_nx  = x_dtr;
        tmo_nx    = tmo_cnt;
        starve_nx = starve_q;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    stb_nx = 1'b1;
                    own_nx = grant_x;
                    tmo_nx = 8'd0;
                    if (grant_x) begin
                        addr_nx = x_addr;
                        rw_nx   = x_rw;
                        dtw_nx  = x_rw ? x_dtw : 32'h0;
                        if (!f_req) begin
                            starve_nx = 4'd0;
                        end else if (starve_q != STARVE_LIM) begin
                            starve_nx = starve_q + 4'd1;
                        end
                    end else begin
                        addr_nx   = f_addr;
                        rw_nx     = 1'b0;
                        dtw_nx    = 32'h0;
                        starve_nx = 4'd0;
                    end
                end
            end
            ST_BUSY: begin
                if (ack_hit || tmo_hit) begin
                    stb_nx = 1'b0;
                    err_nx = tmo_hit;
                    // Writes leave the owner's read-data register untouched.
                    if (!m_rw) begin
                        if (own) x_dtr_nx = rd_data;
                        else     f_dtr_nx = rd_data;
                    end
                    if (own) x_rdy_nx = 1'b1;
                    else     f_rdy_nx = 1'b1;
                end else if (TMO_EN) begin
                    tmo_nx = tmo_cnt + 8'd1;
                end
            end
            default: begin
            end
        endcase
    end

    // Every output is a flop; reset drops m_stb immediately, aborting any transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_stb    <= 1'b0;
            m_addr   <= 32'h0;
            m_rw     <= 1'b0;
            m_dtw    <= 32'h0;
            own      <= 1'b0;
            f_rdy    <= 1'b0;
            x_rdy    <= 1'b0;
            bus_err  <= 1'b0;
            f_dtr    <= 32'h0;
            x_dtr    <= 32'h0;
            tmo_cnt  <= 8'd0;
            starve_q <= 4'd0;
        end else begin
            m_stb    <= stb_nx;
            m_addr   <= addr_nx;
            m_rw     <= rw_nx;
            m_dtw    <= dtw_nx;
            own      <= own_nx;
            f_rdy    <= f_rdy_nx;
            x_rdy    <= x_rdy_nx;
            bus_err  <= err_nx;
            f_dtr    <= f_dtr_nx;
            x_dtr    <= x_dtr_nx;
            tmo_cnt  <= tmo_nx;
            starve_q <= starve_nx;
        end
    end

    assign fsm_state  = state;
    assign starve_cnt = starve_q;

endmodule

// File: doc/hs32_mem_arb.md
# hs32_mem_arb

Two-port memory arbiter that shares the single memory bus between the hs32 fetch unit (instruction reads) and the execute unit (data loads/stores). It sits between the CPU core and the memory/bus fabric. It registers each request, runs exactly one memory transaction at a time, and returns data with a one-cycle ready pulse. Execute has priority, with a bounded-starvation guarantee for fetch and an optional bus timeout.

## Interface
- `STARVE`, 4: max consecutive exec grants while fetch waits; the next arbitration goes to fetch (1..15).
- `TIMEOUT`, 0: BUSY cycles without `m_ack` before abort; 0 disables the timeout (1..255 otherwise).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `f_req`  in  1  fetch request; held high with `f_addr` stable until `f_rdy`.
- `f_addr`  in  32  fetch address (read only).
- `f_rdy`  out  1  one-cycle pulse: fetch transaction complete.
- `f_dtr`  out  32  fetch read data; valid while `f_rdy` is high and held until the next fetch completion.
- `x_req`  in  1  exec request; same handshake as fetch.
- `x_addr`  in  32  exec address.
- `x_rw`  in  1  0 = read, 1 = write.
- `x_dtw`  in  32  exec write data.
- `x_rdy`  out  1  one-cycle pulse: exec transaction complete.
- `x_dtr`  out  32  exec read data; valid with `x_rdy` and held.
- `m_stb`  out  1  memory strobe; high for the whole BUSY state.
- `m_addr`  out  32  latched address.
- `m_rw`  out  1  latched direction.
- `m_dtw`  out  32  latched write data; 0 for reads.
- `m_ack`  in  1  memory acknowledge; completes the transaction when sampled high in BUSY.
- `m_dtr`  in  32  memory read data; sampled on the `m_ack` cycle.
- `own`  out  1  owner of the current or last transaction: 0 = fetch, 1 = exec.
- `bus_err`  out  1  one-cycle pulse alongside `f_rdy`/`x_rdy` when the transaction timed out.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- **IDLE**
  - If neither request is high, stay in IDLE.
  - Otherwise pick the owner:
    - `x_req` only: exec.
    - `f_req` only: fetch.
    - Both high: exec, unless `starve_cnt == STARVE`, in which case fetch.
  - Latch `m_addr`, `m_rw`, `m_dtw` and `own` from the winner. A fetch grant forces `m_rw=0` and `m_dtw=0`.
  - Set `m_stb=1` and go to BUSY.
- **BUSY**
  - `m_addr`, `m_rw` and `m_dtw` stay stable. `req` is no longer sampled.
  - On `m_ack=1`: capture `m_dtr` into the owner's `dtr` register (reads only; writes leave it unchanged), drop `m_stb`, go to DONE.
  - Timeout (`TIMEOUT != 0`): `tmo_cnt` increments each BUSY cycle without ack. When `tmo_cnt == TIMEOUT-1` and `m_ack=0`: drop `m_stb`, load the owner `dtr` with 32'h0 (reads), set the error flag, go to DONE.
  - If ack and timeout expiry coincide, ack wins and no error is raised.
- **DONE**
  - Pulse the owner's `rdy` for exactly one cycle.
  - Pulse `bus_err` in the same cycle if the error flag is set, then clear the flag.
  - Return to IDLE.
  - The requester must drop `req` on the edge that samples `rdy`. A `req` still high in the following IDLE cycle is treated as a new request.
- **Starvation counter** (`starve_cnt`, 4 bits, saturating at STARVE):
  - At each exec grant made while `f_req=1`: increment.
  - At any fetch grant: clear.
  - At an exec grant with `f_req=0`: clear.
- A requester dropping `req` mid-transaction does not abort it. The transaction completes and `rdy` still pulses.
- `f_dtr` and `x_dtr` are independent registers. One port's transaction never alters the other's data.

## Timing
- Reset (async assert) values:
  - state IDLE.
  - `m_stb`, `m_rw`, `f_rdy`, `x_rdy`, `bus_err`, `own` = 0.
  - `m_addr`, `m_dtw`, `f_dtr`, `x_dtr` = 0.
  - `starve_cnt`, `tmo_cnt` = 0.
- Reset asserted mid-BUSY aborts the transaction immediately: `m_stb` drops asynchronously and no `rdy` follows. Deassertion is synchronised by the surrounding reset logic.
- Cycle numbering, with the request sampled high in IDLE at cycle 0:
  - `m_stb` is high from cycle 1.
  - With `m_ack` in cycle k ≥ 1, `rdy` is high in cycle k+1, and IDLE is re-entered at cycle k+2.
- Minimum latency from `req` to `rdy`: 2 cycles. Back-to-back throughput: one transaction per 3 cycles (zero-wait memory).
- `m_ack` outside BUSY is ignored.
- All outputs are registered. There is no combinational path from `*_req` or `m_ack` to any output.
- With `TIMEOUT=N`, an unacked transaction has `m_stb` high for exactly N cycles.

## Test plan
- **Single exec write.** `x_req=1`, `x_addr=32'h100`, `x_rw=1`, `x_dtw=32'hDEADBEEF`; `m_ack` one cycle after `m_stb` rises.
  - Expect `m_addr=32'h100`, `m_rw=1`, `m_dtw=32'hDEADBEEF`, `x_rdy` pulse at cycle 2.
  - Expect `x_dtr` unchanged and no `f_rdy`.
- **Fetch read with wait states.** `f_req=1`, `f_addr=32'h40`; `m_ack` delayed 3 cycles with `m_dtr=32'h12345678`.
  - Expect `m_rw=0`, `f_rdy` at cycle 4, `f_dtr=32'h12345678`, `own=0`.
- **Starvation.** `STARVE=4`, `f_req` held high, `x_req` re-raised immediately after every `x_rdy`, zero-wait memory.
  - Expect grants in the order exec ×4, then fetch, then exec.
  - Expect `starve_cnt` to read 0 after the fetch grant.
- **Timeout.** `TIMEOUT=8`, exec read, `m_ack` never asserted.
  - Expect `m_stb` high for exactly 8 cycles, then `x_rdy` and `bus_err` together, `x_dtr=0`.
  - Repeat with `m_ack` on the 8th BUSY cycle: expect `bus_err=0` and the data captured.
- **Reset mid-transaction.** Pull `reset` low during BUSY.
  - Expect `m_stb=0` in the same cycle, all outputs at reset values, and no `rdy` after release.
  - A new `f_req` then completes normally.
- **Request withdrawn.** `x_req` dropped during BUSY.
  - Expect the transaction to finish and `x_rdy` to pulse once.
  - Expect no second transaction.
